// File: rtl/multicycle_alu.sv
// Registered ALU with carry-chained add/sub, flags-only compare and an N-cycle
// shift-add unsigned multiply behind a start/busy/done handshake.
module multicycle_alu #(
  parameter int unsigned N   = 8,
  parameter int unsigned SHW = $clog2(N) + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [3:0]   op,
  input  logic [N-1:0] in1,
  input  logic [N-1:0] in2,
  output logic [N-1:0] out,
  output logic [N-1:0] out_hi,
  output logic         V,
  output logic         Z,
  output logic         C,
  output logic         S,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam int unsigned CW = $clog2(N);
  localparam logic [SHW-1:0] ShLimit = SHW'(N);

  localparam logic [3:0] OpAdd  = 4'd0;
  localparam logic [3:0] OpSub  = 4'd1;
  localparam logic [3:0] OpOr   = 4'd2;
  localparam logic [3:0] OpAnd  = 4'd3;
  localparam logic [3:0] OpSrl  = 4'd4;
  localparam logic [3:0] OpSll  = 4'd5;
  localparam logic [3:0] OpNot  = 4'd6;
  localparam logic [3:0] OpPass = 4'd7;
  localparam logic [3:0] OpAdc  = 4'd8;
  localparam logic [3:0] OpSbc  = 4'd9;
  localparam logic [3:0] OpCmp  = 4'd10;
  localparam logic [3:0] OpMul  = 4'd11;

  typedef enum logic [0:0] {StIdle, StMul} state_t;

  state_t            state_q;
  logic [N-1:0]      mcand_q;
  logic [2*N-1:0]    prod_q;
  logic [CW-1:0]     cnt_q;

  logic [SHW-1:0]    k;
  logic [N:0]        arith;
  logic [N:0]        shr;
  logic [N:0]        shl;
  logic [N-1:0]      res;
  logic              res_c;
  logic              res_v;
  logic              illegal;
  logic              write_out;
  logic [N:0]        mul_sum;
  logic [2*N-1:0]    mul_next;

  assign k = in2[SHW-1:0];

  always_comb begin
    arith     = '0;
    res       = '0;
    res_c     = 1'b0;
    res_v     = 1'b0;
    illegal   = 1'b0;
    write_out = 1'b1;
    // {A,0}>>k leaves the last bit shifted out in bit 0; {0,A}<<k leaves it in bit N.
    shr       = {in1, 1'b0} >> k;
    shl       = {1'b0, in1} << k;
    case (op)
      OpAdd, OpAdc: begin
        arith = {1'b0, in1} + {1'b0, in2} + {{N{1'b0}}, (op == OpAdc) & C};
        res   = arith[N-1:0];
        res_c = arith[N];
        res_v = (in1[N-1] == in2[N-1]) && (res[N-1] != in1[N-1]);
      end
      OpSub, OpSbc, OpCmp: begin
        arith     = {1'b0, in1} - {1'b0, in2} - {{N{1'b0}}, (op == OpSbc) & C};
        res       = arith[N-1:0];
        res_c     = arith[N];
        res_v     = (in1[N-1] != in2[N-1]) && (res[N-1] != in1[N-1]);
        write_out = (op != OpCmp);
      end
      OpOr:   res = in1 | in2;
      OpAnd:  res = in1 & in2;
      OpNot:  res = ~in1;
      OpPass: res = in1;
      OpSrl: begin
        if (k < ShLimit) begin
          res   = shr[N:1];
          res_c = shr[0];
        end
      end
      OpSll: begin
        if (k < ShLimit) begin
          res   = shl[N-1:0];
          res_c = shl[N];
        end
      end
      OpMul:   ;
      default: illegal = 1'b1;
    endcase
  end

  // Right-shifting product register: multiplier starts in the low half.
  always_comb begin
    mul_sum  = {1'b0, prod_q[2*N-1:N]} + (prod_q[0] ? {1'b0, mcand_q} : {(N+1){1'b0}});
    mul_next = {mul_sum, prod_q[N-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      mcand_q <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      out     <= '0;
      out_hi  <= '0;
      V       <= 1'b0;
      Z       <= 1'b0;
      C       <= 1'b0;
      S       <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            if (op == OpMul) begin
              mcand_q <= in1;
              prod_q  <= {{N{1'b0}}, in2};
              cnt_q   <= CW'(N - 1);
              busy    <= 1'b1;
              state_q <= StMul;
            end else if (illegal) begin
              out    <= '0;
              out_hi <= '0;
              done   <= 1'b1;
              err    <= 1'b1;
            end else begin
              if (write_out) begin
                out    <= res;
                out_hi <= '0;
              end
              V    <= res_v;
              Z    <= ~|res;
              C    <= res_c;
              S    <= res[N-1];
              done <= 1'b1;
            end
          end
        end
        StMul: begin
          prod_q <= mul_next;
          cnt_q  <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            out     <= mul_next[N-1:0];
            out_hi  <= mul_next[2*N-1:N];
            V       <= |mul_next[2*N-1:N];
            Z       <= ~|mul_next;
            C       <= 1'b0;
            S       <= mul_next[2*N-1];
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed bench for multicycle_alu: a vector table of back-to-back single-cycle
// ops, then hand-written MUL, ignored-start and reset-abort sequences.
module tb_multicycle_alu;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [3:0]   op;
  logic [N-1:0] in1;
  logic [N-1:0] in2;
  logic [N-1:0] out;
  logic [N-1:0] out_hi;
  logic         V, Z, C, S;
  logic         busy, done, err;

  int checks   = 0;
  int failures = 0;

  multicycle_alu #(.N(N)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .in1    (in1),
    .in2    (in2),
    .out    (out),
    .out_hi (out_hi),
    .V      (V),
    .Z      (Z),
    .C      (C),
    .S      (S),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] eo;
    logic [3:0] ef;  // {V,Z,C,S}
    logic       ee;
  } vec_t;

  localparam int NV = 24;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] eo, input logic [3:0] ef, input logic ee);
    vec_t v;
    v.op = o; v.a = a; v.b = b; v.eo = eo; v.ef = ef; v.ee = ee;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " out"},    {24'd0, out}, 32'h0);
    check({tag, " out_hi"}, {24'd0, out_hi}, 32'h0);
    check({tag, " flags"},  {28'd0, V, Z, C, S}, 32'h0);
    check({tag, " ctl"},    {29'd0, busy, done, err}, 32'h0);
  endtask

  initial begin
    tbl[0]  = mk(4'd0,  8'h7F, 8'h01, 8'h80, 4'b1001, 1'b0); // ADD overflow
    tbl[1]  = mk(4'd1,  8'h00, 8'h01, 8'hFF, 4'b0011, 1'b0); // SUB borrow
    tbl[2]  = mk(4'd10, 8'h05, 8'h05, 8'hFF, 4'b0100, 1'b0); // CMP holds out
    tbl[3]  = mk(4'd0,  8'hFF, 8'h01, 8'h00, 4'b0110, 1'b0); // ADD carry, zero
    tbl[4]  = mk(4'd8,  8'h00, 8'h00, 8'h01, 4'b0000, 1'b0); // ADC uses C=1
    tbl[5]  = mk(4'd5,  8'h81, 8'h01, 8'h02, 4'b0010, 1'b0); // SLL 1
    tbl[6]  = mk(4'd4,  8'h81, 8'h01, 8'h40, 4'b0010, 1'b0); // SRL 1
    tbl[7]  = mk(4'd5,  8'h01, 8'h08, 8'h00, 4'b0100, 1'b0); // SLL by N
    tbl[8]  = mk(4'd1,  8'h00, 8'h01, 8'hFF, 4'b0011, 1'b0); // SUB sets C
    tbl[9]  = mk(4'd9,  8'h05, 8'h02, 8'h02, 4'b0000, 1'b0); // SBC with C=1
    tbl[10] = mk(4'd2,  8'hF0, 8'h0F, 8'hFF, 4'b0001, 1'b0); // OR
    tbl[11] = mk(4'd3,  8'hF0, 8'h0F, 8'h00, 4'b0100, 1'b0); // AND
    tbl[12] = mk(4'd6,  8'h0F, 8'h00, 8'hF0, 4'b0001, 1'b0); // NOT
    tbl[13] = mk(4'd7,  8'h80, 8'h55, 8'h80, 4'b0001, 1'b0); // PASS
    tbl[14] = mk(4'd1,  8'h80, 8'h01, 8'h7F, 4'b1000, 1'b0); // SUB signed overflow
    tbl[15] = mk(4'd0,  8'h80, 8'h80, 8'h00, 4'b1110, 1'b0); // ADD V,Z,C
    tbl[16] = mk(4'd13, 8'h12, 8'h34, 8'h00, 4'b1110, 1'b1); // illegal: flags hold
    tbl[17] = mk(4'd8,  8'h01, 8'h01, 8'h03, 4'b0000, 1'b0); // ADC C survives illegal
    tbl[18] = mk(4'd4,  8'h80, 8'h07, 8'h01, 4'b0000, 1'b0); // SRL 7
    tbl[19] = mk(4'd5,  8'h03, 8'h07, 8'h80, 4'b0011, 1'b0); // SLL 7, C=A[1]
    tbl[20] = mk(4'd4,  8'hFF, 8'h0F, 8'h00, 4'b0100, 1'b0); // SRL k>N
    tbl[21] = mk(4'd9,  8'h10, 8'h01, 8'h0F, 4'b0000, 1'b0); // SBC with C=0
    tbl[22] = mk(4'd5,  8'hA5, 8'h00, 8'hA5, 4'b0001, 1'b0); // SLL 0
    tbl[23] = mk(4'd4,  8'hA5, 8'h10, 8'hA5, 4'b0001, 1'b0); // SRL k=in2[3:0]=0

    rst = 1'b1; start = 1'b0; op = 4'd0; in1 = '0; in2 = '0;
    step();
    step();
    check_all_zero("reset");
    rst = 1'b0;

    // Back-to-back single-cycle ops, one per clock.
    for (int i = 0; i < NV; i++) begin
      op = tbl[i].op; in1 = tbl[i].a; in2 = tbl[i].b; start = 1'b1;
      step();
      check($sformatf("vec%0d out", i),    {24'd0, out}, {24'd0, tbl[i].eo});
      check($sformatf("vec%0d out_hi", i), {24'd0, out_hi}, 32'h0);
      check($sformatf("vec%0d flags", i),  {28'd0, V, Z, C, S}, {28'd0, tbl[i].ef});
      check($sformatf("vec%0d done/err", i), {30'd0, done, err}, {30'd0, 1'b1, tbl[i].ee});
    end
    start = 1'b0;
    step();
    check("idle done/err", {30'd0, done, err}, 32'h0);
    check("idle hold out", {24'd0, out}, 32'hA5);

    // MUL 0xFF*0xFF with an ADD start mid-flight that must be ignored.
    op = 4'd11; in1 = 8'hFF; in2 = 8'hFF; start = 1'b1;
    step();
    start = 1'b0; in1 = 8'h01; in2 = 8'h02;
    check("mul accept busy/done", {30'd0, busy, done}, 32'h2);
    for (int i = 1; i <= N; i++) begin
      if (i == 3) begin
        op = 4'd0; in1 = 8'h11; in2 = 8'h22; start = 1'b1;
      end
      step();
      start = 1'b0;
      if (i < N) begin
        check($sformatf("mul edge%0d busy/done", i), {30'd0, busy, done}, 32'h2);
        if (i == N - 1) check("mul out hold", {24'd0, out}, 32'hA5);
      end else begin
        check("mul busy/done/err", {29'd0, busy, done, err}, 32'h2);
        check("mul out",    {24'd0, out}, 32'h01);
        check("mul out_hi", {24'd0, out_hi}, 32'hFE);
        check("mul flags",  {28'd0, V, Z, C, S}, {28'd0, 4'b1001});
      end
    end
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("post-mul%0d done", i), {31'd0, done}, 32'h0);
    end
    check("post-mul out hold", {24'd0, out}, 32'h01);

    // Reset during MUL cycle 4 aborts without done.
    op = 4'd11; in1 = 8'h0A; in2 = 8'h0B; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 1; i <= 3; i++) step();
    rst = 1'b1;
    step();
    check_all_zero("abort");
    rst = 1'b0;
    for (int i = 0; i < N + 2; i++) begin
      step();
      check($sformatf("abort idle%0d busy/done", i), {30'd0, busy, done}, 32'h0);
    end

    // Fresh MUL 3x4 after the abort.
    op = 4'd11; in1 = 8'h03; in2 = 8'h04; start = 1'b1;
    step();
    start = 1'b0;
    check("mul2 accept busy", {31'd0, busy}, 32'h1);
    for (int i = 1; i <= N; i++) begin
      step();
      if (i < N) check($sformatf("mul2 edge%0d done", i), {31'd0, done}, 32'h0);
    end
    check("mul2 busy/done", {30'd0, busy, done}, 32'h1);
    check("mul2 out",    {24'd0, out}, 32'h0C);
    check("mul2 out_hi", {24'd0, out_hi}, 32'h0);
    check("mul2 flags",  {28'd0, V, Z, C, S}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
